maze_agent_controller: RTL

Sequencing controller for the maze path-finder. It steps the agent pose through the maze one node per video frame, using a right-hand wall-following rule. Each frame it publishes the probe pose that the window/node-state datapath must evaluate. It then takes that datapath's opening flags and commits the next pose and heading at the frame boundary. It sits between the first-frame parameter extraction (start pose) and the window datapath/overlay drawer.

---
 rtl/maze_pkg.sv | 43 ++++
 rtl/maze_turn_select.sv | 35 +++
 rtl/maze_agent_controller.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: definitions shared by the maze path-finder blocks.
//   - direction one-hot codes, also used by the window/node-state datapath
//   - mode codes for the agent controller
//   - agent FSM state encoding, visible on the agent_state debug output
//   - heading rotation helpers

package maze_pkg;

    // One-hot headings: bit 3 south (+y), bit 2 west (-x), bit 1 north (-y), bit 0 east (+x)
    localparam logic [3:0] DIR_S = 4'b1000;
    localparam logic [3:0] DIR_W = 4'b0100;
    localparam logic [3:0] DIR_N = 4'b0010;
    localparam logic [3:0] DIR_E = 4'b0001;

    localparam logic [1:0] MODE_PAUSE   = 2'b00;
    localparam logic [1:0] MODE_RUN     = 2'b01;
    localparam logic [1:0] MODE_STEP    = 2'b10;
    localparam logic [1:0] MODE_RESTART = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_SCAN   = 3'd2,
        ST_DECIDE = 3'd3,
        ST_COMMIT = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } agent_state_t;

    // Clockwise when seen from above: S -> W -> N -> E -> S
    function automatic logic [3:0] rot_right(input logic [3:0] d);
        return {d[0], d[3:1]};
    endfunction

    function automatic logic [3:0] rot_left(input logic [3:0] d);
        return {d[2:0], d[3]};
    endfunction

    function automatic logic [3:0] rot_back(input logic [3:0] d);
        return {d[1:0], d[3:2]};
    endfunction

endpackage

// File: rtl/maze_turn_select.sv
// maze_turn_select: right-hand wall-following turn choice.
//   i_dir       current one-hot heading
//   i_open_dirs openings at the probe pose (same one-hot encoding)
//   o_next_dir  heading to take: right, else straight, else left, else back
// Purely combinational. Back is taken whenever nothing else is open,
// including when no opening is reported at all.

module maze_turn_select
    import maze_pkg::*;
(
    input  logic [3:0] i_dir,
    input  logic [3:0] i_open_dirs,
    output logic [3:0] o_next_dir
);

    logic [3:0] w_right;
    logic [3:0] w_left;
    logic [3:0] w_back;

    assign w_right = rot_right(i_dir);
    assign w_left  = rot_left(i_dir);
    assign w_back  = rot_back(i_dir);

    always_comb begin
        o_next_dir = w_back;
        if ((i_open_dirs & w_right) != 4'b0000) begin
            o_next_dir = w_right;
        end else if ((i_open_dirs & i_dir) != 4'b0000) begin
            o_next_dir = i_dir;
        end else if ((i_open_dirs & w_left) != 4'b0000) begin
            o_next_dir = w_left;
        end
    end

endmodule

// File: rtl/maze_agent_controller.sv
// maze_agent_controller: steps the maze agent one node per video frame.
// Inputs:
//   clk, reset (sync, active-high), mode (00 pause, 01 run, 10 single-step,
//   11 restart), video_frame_valid (frame envelope), start_valid/start_x/
//   start_y (start pose), probe_valid/open_dirs (datapath result).
// Outputs (all registered):
//   probe_x/probe_y (pose to evaluate), dir (one-hot heading),
//   agent_state (FSM code), step_count, done (sticky), error (sticky).
// Handshake: start_valid and probe_valid are one-cycle strobes with no
// ready/back-pressure; a strobe is consumed only in the state that expects
// it (IDLE for start, SCAN for probe) and silently dropped elsewhere.

module maze_agent_controller
    import maze_pkg::*;
#(
    parameter int STEP      = 18,
    parameter int IMG_W     = 702,
    parameter int IMG_H     = 288,
    parameter int MARGIN    = 16,
    parameter int MAX_STEPS = 1023
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       video_frame_valid,
    input  logic       start_valid,
    input  logic [9:0] start_x,
    input  logic [9:0] start_y,
    input  logic       probe_valid,
    input  logic [3:0] open_dirs,
    output logic [9:0] probe_x,
    output logic [9:0] probe_y,
    output logic [3:0] dir,
    output logic [2:0] agent_state,
    output logic [9:0] step_count,
    output logic       done,
    output logic       error
);

    // Candidate pose is formed with headroom and sign so that underflow
    // below zero is seen as out of range rather than wrapping.
    localparam logic signed [11:0] L_STEP   = 12'(STEP);
    localparam logic signed [11:0] L_MARGIN = 12'(MARGIN);
    localparam logic signed [11:0] L_XMAX   = 12'(IMG_W - 1 - MARGIN);
    localparam logic signed [11:0] L_YMAX   = 12'(IMG_H - 1 - MARGIN);
    localparam logic [9:0]         L_MAXST  = 10'(MAX_STEPS);

    agent_state_t r_state, w_state_nxt;
    logic       r_vfv_z;
    logic [9:0] r_x, w_x_nxt;
    logic [9:0] r_y, w_y_nxt;
    logic [3:0] r_dir, w_dir_nxt;
    logic [9:0] r_steps, w_steps_nxt;
    logic       r_done, w_done_nxt;
    logic       r_error, w_error_nxt;
    logic       r_miss, w_miss_nxt;       // one frame already ended without a probe
    logic       r_hold, w_hold_nxt;       // single-step: park in SCAN until mode leaves 10
    logic [3:0] r_open, w_open_nxt;
    logic [3:0] r_next_dir, w_next_dir_nxt;

    logic              w_frame_end;
    logic              w_active;
    logic [3:0]        w_turn_dir;
    logic signed [11:0] w_cx;
    logic signed [11:0] w_cy;
    logic              w_in_range;
    logic              w_exit;
    logic [9:0]        w_steps_inc;

    assign w_frame_end = r_vfv_z & ~video_frame_valid;
    assign w_active    = (mode != MODE_PAUSE);
    assign w_steps_inc = r_steps + 10'd1;

    maze_turn_select u_turn (
        .i_dir       (r_dir),
        .i_open_dirs (r_open),
        .o_next_dir  (w_turn_dir)
    );

    always_comb begin
        w_cx = $signed({2'b00, r_x});
        w_cy = $signed({2'b00, r_y});
        case (r_next_dir)
            DIR_S:   w_cy = w_cy + L_STEP;
            DIR_N:   w_cy = w_cy - L_STEP;
            DIR_E:   w_cx = w_cx + L_STEP;
            DIR_W:   w_cx = w_cx - L_STEP;
            default: ;
        endcase
    end

    assign w_in_range = (w_cx >= L_MARGIN) && (w_cx <= L_XMAX) &&
                        (w_cy >= L_MARGIN) && (w_cy <= L_YMAX);
    // Leaving through the bottom edge is the exit, not a fault
    assign w_exit     = (r_next_dir == DIR_S) && (w_cy > L_YMAX);

    always_comb begin
        w_state_nxt    = r_state;
        w_x_nxt        = r_x;
        w_y_nxt        = r_y;
        w_dir_nxt      = r_dir;
        w_steps_nxt    = r_steps;
        w_done_nxt     = r_done;
        w_error_nxt    = r_error;
        w_miss_nxt     = r_miss;
        w_hold_nxt     = r_hold;
        w_open_nxt     = r_open;
        w_next_dir_nxt = r_next_dir;

        case (r_state)
            ST_IDLE: begin
                if (start_valid) begin
                    w_x_nxt     = start_x;
                    w_y_nxt     = start_y;
                    w_dir_nxt   = DIR_S;
                    w_steps_nxt = 10'd0;
                    w_miss_nxt  = 1'b0;
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (w_frame_end) w_state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (r_hold) begin
                    if (mode != MODE_STEP) w_hold_nxt = 1'b0;
                end else if (probe_valid && w_active) begin
                    // A probe coinciding with a frame end wins; commit waits a frame
                    w_open_nxt  = open_dirs;
                    w_miss_nxt  = 1'b0;
                    w_state_nxt = ST_DECIDE;
                end else if (w_frame_end && w_active) begin
                    if (r_miss) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = ST_ERROR;
                    end else begin
                        w_miss_nxt = 1'b1;
                    end
                end
            end
            ST_DECIDE: begin
                w_next_dir_nxt = w_turn_dir;
                w_state_nxt    = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (w_frame_end && w_active) begin
                    if (w_exit) begin
                        w_x_nxt     = w_cx[9:0];
                        w_y_nxt     = w_cy[9:0];
                        w_dir_nxt   = r_next_dir;
                        w_steps_nxt = w_steps_inc;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else if (!w_in_range) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = ST_ERROR;
                    end else begin
                        w_x_nxt     = w_cx[9:0];
                        w_y_nxt     = w_cy[9:0];
                        w_dir_nxt   = r_next_dir;
                        w_steps_nxt = w_steps_inc;
                        if (w_steps_inc == L_MAXST) begin
                            w_error_nxt = 1'b1;
                            w_state_nxt = ST_ERROR;
                        end else begin
                            w_hold_nxt  = (mode == MODE_STEP);
                            w_state_nxt = ST_SCAN;
                        end
                    end
                end
            end
            ST_DONE:  ;
            ST_ERROR: ;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_vfv_z <= 1'b0;
        else       r_vfv_z <= video_frame_valid;
    end

    always_ff @(posedge clk) begin
        if (reset || mode == MODE_RESTART) begin
            r_state    <= ST_IDLE;
            r_x        <= 10'd0;
            r_y        <= 10'd0;
            r_dir      <= DIR_S;
            r_steps    <= 10'd0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_miss     <= 1'b0;
            r_hold     <= 1'b0;
            r_open     <= 4'b0000;
            r_next_dir <= DIR_S;
        end else begin
            r_state    <= w_state_nxt;
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_dir      <= w_dir_nxt;
            r_steps    <= w_steps_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            r_miss     <= w_miss_nxt;
            r_hold     <= w_hold_nxt;
            r_open     <= w_open_nxt;
            r_next_dir <= w_next_dir_nxt;
        end
    end

    assign probe_x     = r_x;
    assign probe_y     = r_y;
    assign dir         = r_dir;
    assign agent_state = r_state;
    assign step_count  = r_steps;
    assign done        = r_done;
    assign error       = r_error;

endmodule
